serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full-adder cell across a WIDTH-bit add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    logic [WIDTH-1:0] sh_d;
    logic [CNT_W-1:0] count_d;
    logic             run_c;

    // Next values of the sum shifter and bit counter during RUN
    always_comb begin
        sh_d    = {fa_s, sh_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
    end

    assign run_c = (state_q == RUN);

    // Full-adder operands are gated to zero outside RUN
    assign fa_a   = run_c & opa_q[0];
    assign fa_b   = run_c & opb_q[0];
    assign fa_cin = run_c & carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sh_q    <= sh_d;
                    carry_q <= fa_c;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    count_q <= count_d;
                    // Last bit: publish the result on the same edge
                    if (count_q == LAST_CNT) begin
                        sum_q   <= sh_d;
                        cout_q  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= carry_q ^ fa_c;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and reference-model bench for serial_add_ctrl at WIDTH=8 and WIDTH=2,
// each DUT paired with a behavioural full-adder cell.
module tb_serial_add_ctrl;

    logic clk;
    logic reset;

    logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_s8, fa_c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, fa_a2, fa_b2, fa_cin2, fa_s2, fa_c2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf2;
`endif

    int checks   = 0;
    int failures = 0;

    // Results gathered by do_op
    logic [7:0] res_sum;
    logic       res_cout;
    logic       res_ovf;
    int         busy_n, done_n, done_at, overlap, fa_idle_nz;
    logic [7:0] fcin_trace;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_c(fa_c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2), .fa_s(fa_s2), .fa_c(fa_c2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf2)
`endif
    );

    assign fa_s8 = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_c8 = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8));
    assign fa_s2 = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_c2 = (fa_a2 & fa_b2) | (fa_cin2 & (fa_a2 ^ fa_b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed overflow reference for a w-bit add
    function automatic logic ovf_ref(input int w, input logic [7:0] av, input logic [7:0] bv,
                                     input logic [7:0] s);
        return (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    endfunction

    // Issue one start, then watch WIDTH+3 cycles collecting timing and result
    task automatic do_op(input bit w2, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int   w;
        logic sb, sd, fany, fc;
        w = w2 ? 2 : 8;
        if (w2) begin
            start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; cin2 = cv;
        end else begin
            start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        end
        tick();
        start8 = 1'b0; start2 = 1'b0;
        a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
        busy_n = 0; done_n = 0; done_at = -1; overlap = 0; fa_idle_nz = 0; fcin_trace = '0;
        for (int i = 0; i < w + 3; i++) begin
            sb   = w2 ? busy2 : busy8;
            sd   = w2 ? done2 : done8;
            fc   = w2 ? fa_cin2 : fa_cin8;
            fany = w2 ? (fa_a2 | fa_b2 | fa_cin2) : (fa_a8 | fa_b8 | fa_cin8);
            if (sb) begin
                busy_n++;
                if (i < 8) fcin_trace[i] = fc;
            end else if (fany) begin
                fa_idle_nz++;
            end
            if (sd) begin
                done_n++;
                done_at = i;
            end
            if (sb && sd) overlap++;
            tick();
        end
        res_sum  = w2 ? {6'b0, sum2} : sum8;
        res_cout = w2 ? cout2 : cout8;
`ifdef SERIAL_ADD_OVF_EN
        res_ovf  = w2 ? ovf2 : ovf8;
`else
        res_ovf  = 1'b0;
`endif
    endtask

    task automatic check_op(input string tag, input int w, input logic [7:0] es,
                            input logic ec, input logic eo);
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(w));
        chk({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, ".done_cycle"}, 32'(done_at), 32'(w));
        chk({tag, ".busy_done_overlap"}, 32'(overlap), 32'd0);
        chk({tag, ".fa_idle"}, 32'(fa_idle_nz), 32'd0);
        chk({tag, ".sum"}, 32'(res_sum), 32'(es));
        chk({tag, ".cout"}, 32'(res_cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, ".ovf"}, 32'(res_ovf), 32'(eo));
`else
        if (eo === 1'bx) chk({tag, ".ovf_x"}, 32'(res_ovf), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] av, bv;
        logic       cv;
        logic [8:0] e9;
        logic [2:0] e3;
        int         rise_at, d1_at, d2_at, n_done;
        logic       prev_busy;

        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst.busy8", 32'(busy8), 32'd0);
        chk("rst.done8", 32'(done8), 32'd0);
        chk("rst.sum8", 32'(sum8), 32'd0);
        chk("rst.cout8", 32'(cout8), 32'd0);
        chk("rst.fa8", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
        chk("rst.busy2", 32'(busy2), 32'd0);
        chk("rst.sum2", 32'(sum2), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst.ovf8", 32'(ovf8), 32'd0);
`endif

        // Directed vectors
        do_op(1'b0, 8'h5A, 8'h3C, 1'b0);
        check_op("v5a3c", 8, 8'h96, 1'b0, 1'b1);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0);
        check_op("vff01", 8, 8'h00, 1'b1, 1'b0);
        chk("vff01.fa_cin_trace", 32'(fcin_trace), 32'h0000_00FE);
        do_op(1'b0, 8'h00, 8'h00, 1'b1);
        check_op("v0001", 8, 8'h01, 1'b0, 1'b0);
        chk("v0001.fa_cin_trace", 32'(fcin_trace), 32'h0000_0001);

        // Start held high; the operands presented during RUN/DONE wait for the next accept
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        a8 = 8'h77; b8 = 8'h11;
        rise_at = -1; d1_at = -1; d2_at = -1; n_done = 0; prev_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy8 && !prev_busy && rise_at < 0) rise_at = i;
            prev_busy = busy8;
            if (done8) begin
                n_done++;
                if (d1_at < 0) begin
                    d1_at = i;
                    chk("hold.first_sum", 32'(sum8), 32'h46);
                end else begin
                    d2_at = i;
                    chk("hold.second_sum", 32'(sum8), 32'h88);
                    start8 = 1'b0;
                end
            end
            tick();
        end
        start8 = 1'b0;
        chk("hold.first_done", 32'(d1_at), 32'd8);
        chk("hold.next_accept", 32'(rise_at), 32'd10);
        chk("hold.second_done", 32'(d2_at), 32'd18);
        chk("hold.done_count", 32'(n_done), 32'd2);
        tick();
        tick();

        // Reset in the 4th busy cycle aborts without a done pulse
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("abort.busy_before", 32'(busy8), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.busy", 32'(busy8), 32'd0);
        chk("abort.done", 32'(done8), 32'd0);
        chk("abort.sum", 32'(sum8), 32'd0);
        chk("abort.cout", 32'(cout8), 32'd0);
        chk("abort.fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) n_done++;
            tick();
        end
        chk("abort.no_activity", 32'(n_done), 32'd0);
        do_op(1'b0, 8'h01, 8'h01, 1'b0);
        check_op("after_abort", 8, 8'h02, 1'b0, 1'b0);

        // Width-2 directed boundary cases
        do_op(1'b1, 8'h03, 8'h01, 1'b0);
        check_op("w2_3p1", 2, 8'h00, 1'b1, 1'b0);
        do_op(1'b1, 8'h01, 8'h01, 1'b0);
        check_op("w2_1p1", 2, 8'h02, 1'b0, 1'b1);

        // Reference-model sweep at both widths
        for (int n = 0; n < 500; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            cv = 1'($urandom);
            e9 = {1'b0, av} + {1'b0, bv} + 9'(cv);
            do_op(1'b0, av, bv, cv);
            check_op("rand8", 8, e9[7:0], e9[8], ovf_ref(8, av, bv, e9[7:0]));
        end
        for (int n = 0; n < 500; n++) begin
            av = 8'($urandom_range(0, 3));
            bv = 8'($urandom_range(0, 3));
            cv = 1'($urandom);
            e3 = 3'(av) + 3'(bv) + 3'(cv);
            do_op(1'b1, av, bv, cv);
            check_op("rand2", 2, {6'b0, e3[1:0]}, e3[2], ovf_ref(2, av, bv, {6'b0, e3[1:0]}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
